// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC interpolator input feed.
//   - feed_state_e : scheduler state encoding (IDLE=0, PRIME=1, RUN=2), also
//                    exported on cic_feed_ctrl.state_o.
//   - CIC_BIT_WIDTH / CIC_INTERP_RATE : default sample width and interpolation
//                    rate, shared with the interpolator so both sides agree.
// -----------------------------------------------------------------------------
package cic_pkg;

  localparam int CIC_BIT_WIDTH   = 4;
  localparam int CIC_INTERP_RATE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feed_state_e;

endpackage

// File: rtl/cic_feed_fifo.sv
// -----------------------------------------------------------------------------
// cic_feed_fifo
// Small synchronous sample FIFO for the CIC feed scheduler.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush_i          empty the FIFO (takes priority over push/pop)
//   push_i           write push_data_i (ignored when full)
//   push_data_i      sample to store
//   pop_i            drop the head entry (ignored when empty)
//   head_o           current head entry (valid when !empty_o)
//   level_o          occupancy, 0..DEPTH
//   full_o, empty_o  occupancy flags
// -----------------------------------------------------------------------------
module cic_feed_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = level_q;
  // Head is read combinationally so a load edge can capture it directly.
  assign head_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/cic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// cic_feed_ctrl
// Input-side sample scheduler for the CIC interpolator. Buffers upstream
// samples and presents exactly one new sample per interpolation frame,
// phase-aligned with the interpolator's up-sample counter.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   run            1 = stream, 0 = stop at the next frame boundary
//   s_valid/s_data/s_ready   upstream sample handshake (signed samples)
//   cic_enable     interpolator enable (high throughout RUN)
//   cic_data       interpolator data_in, changes only on load edges
//   cic_phase      mirror of the interpolator up-sample counter
//   underrun       one-cycle pulse when a load finds the FIFO empty
//   underrun_cnt   saturating underrun count, cleared only by reset
//   fifo_level     FIFO occupancy
//   state_o        IDLE=0, PRIME=1, RUN=2
// Build option:
//   CIC_FEED_HOLD_EN  when defined, an underrun repeats the previous sample;
//                     otherwise it zero-stuffs. Stopping always zeroes data.
// -----------------------------------------------------------------------------
module cic_feed_ctrl
  import cic_pkg::*;
#(
  parameter int BIT_WIDTH   = CIC_BIT_WIDTH,
  parameter int INTERP_RATE = CIC_INTERP_RATE,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2,
  parameter int UCNT_WIDTH  = 8,
  localparam int PW         = $clog2(INTERP_RATE),
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        s_valid,
  input  logic signed [BIT_WIDTH-1:0] s_data,
  output logic                        s_ready,
  output logic                        cic_enable,
  output logic signed [BIT_WIDTH-1:0] cic_data,
  output logic [PW-1:0]               cic_phase,
  output logic                        underrun,
  output logic [UCNT_WIDTH-1:0]       underrun_cnt,
  output logic [LW-1:0]               fifo_level,
  output logic [1:0]                  state_o
);

  feed_state_e           state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [BIT_WIDTH-1:0]  data_q, data_d;
  logic                  underrun_q, underrun_d;
  logic [UCNT_WIDTH-1:0] ucnt_q, ucnt_d;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [BIT_WIDTH-1:0]  fifo_head;
  logic [LW-1:0]         fifo_lvl;
  logic                  frame_end, prime_done, load;

  assign frame_end  = (state_q == RUN) && (phase_q == PW'(INTERP_RATE - 1));
  assign prime_done = (state_q == PRIME) && run && (fifo_lvl >= LW'(PRIME_LEVEL));
  assign load       = prime_done || (frame_end && run);
  // The FIFO is held empty in IDLE and emptied on every exit to IDLE.
  assign fifo_flush = (state_q == IDLE) || ((state_q == PRIME) && !run) ||
                      (frame_end && !run);
  assign fifo_pop   = load && !fifo_empty;
  // s_ready looks at the registered level only: a pop in the same cycle
  // does not open a slot while full.
  assign s_ready    = (state_q != IDLE) && !fifo_full;
  assign fifo_push  = s_valid && s_ready;

  cic_feed_fifo #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (s_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .level_o     (fifo_lvl),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        data_d  = '0;
        if (run) state_d = PRIME;
      end
      PRIME: begin
        if (!run)            state_d = IDLE;
        else if (prime_done) state_d = RUN;
      end
      RUN: begin
        phase_d = frame_end ? '0 : phase_q + PW'(1);
        if (frame_end && !run) begin
          state_d = IDLE;
          data_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        data_d  = '0;
      end
    endcase

    if (load) begin
      if (!fifo_empty) begin
        data_d = fifo_head;
      end else begin
        underrun_d = 1'b1;
        if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_WIDTH'(1);
`ifdef CIC_FEED_HOLD_EN
        data_d = data_q;
`else
        data_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign cic_enable   = (state_q == RUN);
  assign cic_data     = data_q;
  assign cic_phase    = phase_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  assign fifo_level   = fifo_lvl;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_feed_ctrl
// Directed bench for cic_feed_ctrl at default parameters (R=8, DEPTH=4,
// PRIME=2). Accepted samples are queued as expected frame data and popped at
// each frame start (phase 0 with cic_enable high). Outputs are sampled on the
// falling edge; inputs are driven right after it.
// -----------------------------------------------------------------------------
module tb_cic_feed_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              s_valid;
  logic signed [3:0] s_data;
  logic              s_ready;
  logic              cic_enable;
  logic signed [3:0] cic_data;
  logic [2:0]        cic_phase;
  logic              underrun;
  logic [7:0]        underrun_cnt;
  logic [2:0]        fifo_level;
  logic [1:0]        state_o;

  int n_assert = 0;
  int n_fail   = 0;
  int sb[$];
  int last_data = 0;
  int model_lvl;
  int vals[5] = '{1, 2, 3, 4, 6};

  always #5 clk = ~clk;

  cic_feed_ctrl #(
    .BIT_WIDTH   (4),
    .INTERP_RATE (8),
    .FIFO_DEPTH  (4),
    .PRIME_LEVEL (2),
    .UCNT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .cic_enable   (cic_enable),
    .cic_data     (cic_data),
    .cic_phase    (cic_phase),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level),
    .state_o      (state_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int d_u();
    logic [3:0] t;
    t = cic_data;
    return int'(t);
  endfunction

  // Advance to the next frame start, bounded to two frames.
  task automatic next_frame();
    int k = 0;
    int found = 0;
    do begin
      tick();
      k++;
      if (cic_enable && cic_phase == 3'd0) found = 1;
    end while (!found && k < 16);
    chk("frame_found", found, 1);
  endtask

  // Frame-start check: either the next queued sample or an underrun.
  task automatic frame_check(input string tag);
    int exp;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      last_data = exp;
      chk({tag, "_data"}, d_u(), exp);
      chk({tag, "_no_underrun"}, int'(underrun), 0);
    end else begin
`ifdef CIC_FEED_HOLD_EN
      exp = last_data;
`else
      exp = 0;
      last_data = 0;
`endif
      chk({tag, "_underrun_data"}, d_u(), exp);
      chk({tag, "_underrun_pulse"}, int'(underrun), 1);
    end
    $display("frame: phase=%0d data=%0d underrun=%0d cnt=%0d level=%0d",
             cic_phase, d_u(), underrun, underrun_cnt, fifo_level);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_enable"}, int'(cic_enable), 0);
    chk({tag, "_data"}, d_u(), 0);
    chk({tag, "_phase"}, int'(cic_phase), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_ucnt"}, int'(underrun_cnt), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; s_valid = 1'b0; s_data = '0;

    // Reset state
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Start-up: prime with 3, 5
    run = 1'b1;
    tick();
    chk("prime_state", int'(state_o), 1);
    chk("prime_s_ready", int'(s_ready), 1);
    chk("prime_enable", int'(cic_enable), 0);
    s_valid = 1'b1; s_data = 4'sd3; sb.push_back(3);
    tick();
    chk("prime_level1", int'(fifo_level), 1);
    s_data = 4'sd5; sb.push_back(5);
    tick();
    chk("prime_level2", int'(fifo_level), 2);
    chk("prime_state2", int'(state_o), 1);
    s_valid = 1'b0;
    tick();
    chk("startup_state", int'(state_o), 2);
    chk("startup_phase", int'(cic_phase), 0);
    chk("startup_enable", int'(cic_enable), 1);
    chk("startup_level", int'(fifo_level), 1);
    frame_check("startup");
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("phase_count", int'(cic_phase), i);
    end
    next_frame();
    frame_check("second");
    chk("second_level", int'(fifo_level), 0);

    // Underrun
    next_frame();
    frame_check("underrun1");
    chk("underrun1_cnt", int'(underrun_cnt), 1);
    tick();
    chk("underrun_pulse_end", int'(underrun), 0);
    repeat (255) next_frame();
    frame_check("underrun_sat");
    chk("underrun_sat_cnt", int'(underrun_cnt), 255);

    // Full: push continuously from phase 0
    model_lvl = 0;
    for (int i = 0; i < 5; i++) begin
      chk("full_s_ready", int'(s_ready), (model_lvl < 4) ? 1 : 0);
      s_valid = 1'b1; s_data = 4'(vals[i]);
      if (model_lvl < 4) begin
        sb.push_back(vals[i]);
        model_lvl++;
      end
      tick();
      chk("full_level", int'(fifo_level), model_lvl);
    end
    s_valid = 1'b0;
    chk("full_s_ready_low", int'(s_ready), 0);
    next_frame();
    frame_check("full_load");
    chk("full_load_level", int'(fifo_level), 3);
    chk("full_load_s_ready", int'(s_ready), 1);
    next_frame();
    frame_check("full_load2");

    // Stop: drop run at phase 3
    repeat (3) tick();
    chk("stop_phase3", int'(cic_phase), 3);
    run = 1'b0;
    for (int ph = 4; ph < 8; ph++) begin
      tick();
      chk("stop_enable", int'(cic_enable), 1);
      chk("stop_phase", int'(cic_phase), ph);
    end
    tick();
    chk("stop_state", int'(state_o), 0);
    chk("stop_phase0", int'(cic_phase), 0);
    chk("stop_level", int'(fifo_level), 0);
    chk("stop_data", d_u(), 0);
    chk("stop_enable_low", int'(cic_enable), 0);
    chk("stop_no_underrun", int'(underrun), 0);
    chk("stop_ucnt_kept", int'(underrun_cnt), 255);
    sb.delete();
    last_data = 0;

    // Abort prime with level 1
    run = 1'b1;
    tick();
    chk("abort_prime_state", int'(state_o), 1);
    s_valid = 1'b1; s_data = 4'sd7;
    tick();
    chk("abort_level1", int'(fifo_level), 1);
    chk("abort_enable_a", int'(cic_enable), 0);
    s_valid = 1'b0; run = 1'b0;
    tick();
    chk("abort_state", int'(state_o), 0);
    chk("abort_level0", int'(fifo_level), 0);
    chk("abort_enable_b", int'(cic_enable), 0);

    // Reset mid-RUN, asserted between edges
    run = 1'b1;
    tick();
    s_valid = 1'b1; s_data = 4'sd3; sb.push_back(3);
    tick();
    s_data = 4'sd5; sb.push_back(5);
    tick();
    s_valid = 1'b0;
    tick();
    chk("rerun_state", int'(state_o), 2);
    frame_check("rerun");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    sb.delete();
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
